fetch_queue_unit: RTL

- Parametrised next-generation instruction fetcher: generates the PC, looks up the I-cache, falls back to the memory controller on a miss, predicts JAL/branch targets, and buffers fetched instructions in a DEPTH-entry FIFO.
- The FIFO decouples fetch from decode with a valid/ready pop handshake, replacing the single-register stall-coupled output of the previous fetcher.
- Sits between I-cache/memory controller/predictor and the decoder.
- A ROB redirect flushes the FIFO and any in-flight miss.

---
 rtl/fetch_queue_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : PC generation, I-cache lookup with memory-controller miss path,
//            static JAL/branch target prediction and a DEPTH-entry fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
   parameter int unsigned           ADDR_W   = 32,
   parameter int unsigned           DEPTH    = 4,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clr_in,
   input  logic [ADDR_W-1:0] clr_pc,
   output logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_hit,
   input  logic [31:0]       ic_inst,
   output logic              ic_wr_valid,
   output logic [ADDR_W-1:0] ic_wr_addr,
   output logic [31:0]       ic_wr_inst,
   output logic              mc_req,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_done,
   input  logic [31:0]       mc_inst,
   output logic [ADDR_W-1:0] pr_pc,
   input  logic              pr_taken,
   output logic              dq_valid,
   input  logic              dq_ready,
   output logic [ADDR_W-1:0] dq_pc,
   output logic [31:0]       dq_inst,
   output logic              dq_pred
);

   localparam int unsigned          c_PTR_W     = $clog2(DEPTH);
   localparam int unsigned          c_CNT_W     = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0]   c_DEPTH_CNT = c_CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0]    c_PC_STEP   = ADDR_W'(4);
   localparam logic [6:0]           c_OP_JAL    = 7'b1101111;
   localparam logic [6:0]           c_OP_BRANCH = 7'b1100011;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUSY = 2'd1;
   localparam logic [1:0] c_KILL = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;

   logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
   logic [31:0]        r_q_inst [DEPTH];
   logic               r_q_pred [DEPTH];

   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic               w_miss;
   logic               w_refill;
   logic [31:0]        w_cur_inst;
   logic [ADDR_W-1:0]  w_j_imm;
   logic [ADDR_W-1:0]  w_b_imm;
   logic [ADDR_W-1:0]  w_next_pc;
   logic               w_next_pred;

   assign w_full   = (r_count == c_DEPTH_CNT);
   assign dq_valid = (r_count != '0);
   assign dq_pc    = r_q_pc[r_head];
   assign dq_inst  = r_q_inst[r_head];
   assign dq_pred  = r_q_pred[r_head];
   assign ic_addr  = r_pc;
   assign pr_pc    = r_pc;

   // Refill data bypasses the cache lookup in the cycle the response arrives.
   assign w_cur_inst = (r_state == c_BUSY && mc_done) ? mc_inst : ic_inst;

   assign w_j_imm = {{(ADDR_W-21){w_cur_inst[31]}}, w_cur_inst[31], w_cur_inst[19:12],
                     w_cur_inst[20], w_cur_inst[30:21], 1'b0};
   assign w_b_imm = {{(ADDR_W-13){w_cur_inst[31]}}, w_cur_inst[31], w_cur_inst[7],
                     w_cur_inst[30:25], w_cur_inst[11:8], 1'b0};

   always_comb begin
      w_next_pc   = r_pc + c_PC_STEP;
      w_next_pred = 1'b0;
      if (w_cur_inst[6:0] == c_OP_JAL) begin
         w_next_pc   = r_pc + w_j_imm;
         w_next_pred = 1'b1;
      end else if (w_cur_inst[6:0] == c_OP_BRANCH && pr_taken) begin
         w_next_pc   = r_pc + w_b_imm;
         w_next_pred = 1'b1;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (rdy_in) begin
         if (clr_in) begin
            // A response landing with the flush retires the outstanding request.
            if (r_state == c_BUSY || r_state == c_KILL) begin
               w_state_nxt = mc_done ? c_IDLE : c_KILL;
            end else begin
               w_state_nxt = c_IDLE;
            end
         end else begin
            case (r_state)
               c_IDLE:  if (!w_full && !ic_hit) w_state_nxt = c_BUSY;
               c_BUSY:  if (mc_done) w_state_nxt = c_IDLE;
               c_KILL:  if (mc_done) w_state_nxt = c_IDLE;
               default: w_state_nxt = c_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      w_push   = 1'b0;
      w_miss   = 1'b0;
      w_refill = 1'b0;
      mc_req   = (r_state == c_BUSY);
      if (rdy_in && !clr_in) begin
         case (r_state)
            c_IDLE: begin
               if (!w_full) begin
                  w_push = ic_hit;
                  w_miss = !ic_hit;
               end
            end
            c_BUSY: begin
               w_push   = mc_done;
               w_refill = mc_done;
            end
            default: begin
               w_push = 1'b0;
            end
         endcase
      end
   end

   assign w_pop = rdy_in && !clr_in && dq_valid && dq_ready;

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pc        <= RESET_PC;
         r_count     <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         mc_addr     <= '0;
         ic_wr_valid <= 1'b0;
         ic_wr_addr  <= '0;
         ic_wr_inst  <= '0;
      end else begin
         ic_wr_valid <= 1'b0;
         if (rdy_in) begin
            if (clr_in) begin
               r_pc    <= clr_pc;
               r_count <= '0;
               r_head  <= '0;
               r_tail  <= '0;
            end else begin
               if (w_push) begin
                  r_pc   <= w_next_pc;
                  r_tail <= r_tail + 1'b1;
               end
               if (w_pop) begin
                  r_head <= r_head + 1'b1;
               end
               case ({w_push, w_pop})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
               if (w_miss) begin
                  mc_addr <= r_pc;
               end
               if (w_refill) begin
                  ic_wr_valid <= 1'b1;
                  ic_wr_addr  <= r_pc;
                  ic_wr_inst  <= mc_inst;
               end
            end
         end
      end
   end

   // Queue storage carries no reset; entries are only observed while counted.
   always_ff @(posedge clk_in) begin
      if (w_push && !rst_in) begin
         r_q_pc[r_tail]   <= r_pc;
         r_q_inst[r_tail] <= w_cur_inst;
         r_q_pred[r_tail] <= w_next_pred;
      end
   end

endmodule

`default_nettype wire
